// File: rtl/uart_cfg_sequencer.sv
// Programs a 16550-style UART over Wishbone after reset, then hands the
// bus to the host. Ack timeouts abort the sequence and raise a sticky flag.
module uart_cfg_sequencer #(
   parameter logic [15:0] DIVISOR = 16'd27,
   parameter logic [7:0]  LCR_VAL = 8'h03,
   parameter logic [7:0]  FCR_VAL = 8'hC7,
   parameter logic [7:0]  IER_VAL = 8'h01,
   parameter logic [7:0]  TIMEOUT = 8'd255
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       start_i,
   output logic       done_o,
   output logic       busy_o,
   output logic       err_o,
   input  logic [4:0] s_adr_i,
   input  logic [7:0] s_dat_i,
   output logic [7:0] s_dat_o,
   input  logic       s_we_i,
   input  logic       s_cyc_i,
   input  logic       s_stb_i,
   output logic       s_ack_o,
   output logic [4:0] m_adr_o,
   output logic [7:0] m_dat_o,
   input  logic [7:0] m_dat_i,
   output logic [3:0] m_sel_o,
   output logic       m_we_o,
   output logic       m_cyc_o,
   output logic       m_stb_o,
   input  logic       m_ack_i
);

   typedef enum logic [1:0] {
      IDLE_GAP,
      REQ,
      WAIT,
      DONE
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [2:0] step;
   logic [2:0] step_n;
   logic [7:0] tcnt;
   logic [7:0] tcnt_n;
   logic       pend;
   logic       pend_n;
   logic       err;
   logic       err_n;
   logic [4:0] tbl_adr;
   logic [7:0] tbl_dat;
   logic       in_seq;
   logic       go;

   // Step table: DLAB on, divisor low/high, DLAB off, FIFO, IRQ enable
   always_comb begin
      tbl_adr = 5'd0;
      tbl_dat = 8'h00;
      unique case (step)
         3'd0: begin tbl_adr = 5'd3; tbl_dat = LCR_VAL | 8'h80; end
         3'd1: begin tbl_adr = 5'd0; tbl_dat = DIVISOR[7:0];    end
         3'd2: begin tbl_adr = 5'd1; tbl_dat = DIVISOR[15:8];   end
         3'd3: begin tbl_adr = 5'd3; tbl_dat = LCR_VAL & 8'h7F; end
         3'd4: begin tbl_adr = 5'd2; tbl_dat = FCR_VAL;         end
         3'd5: begin tbl_adr = 5'd1; tbl_dat = IER_VAL;         end
         default: begin tbl_adr = 5'd0; tbl_dat = 8'h00;        end
      endcase
   end

   // A restart fires only once the host has released its cycle
   assign go = (start_i || pend) && !s_cyc_i;

   // Next-state logic for the write sequencer
   always_comb begin
      state_n = state;
      step_n  = step;
      tcnt_n  = tcnt;
      pend_n  = pend;
      err_n   = err;
      unique case (state)
         IDLE_GAP: state_n = REQ;
         REQ: begin
            state_n = WAIT;
            tcnt_n  = 8'd0;
         end
         WAIT: begin
            if (m_ack_i) begin
               if (step == 3'd5) begin
                  state_n = DONE;
               end else begin
                  step_n  = step + 3'd1;
                  state_n = IDLE_GAP;
               end
            end else if (tcnt == TIMEOUT - 8'd1) begin
               state_n = DONE;
               err_n   = 1'b1;
            end else begin
               tcnt_n = tcnt + 8'd1;
            end
         end
         DONE: begin
            if (go) begin
               state_n = REQ;
               step_n  = 3'd0;
               err_n   = 1'b0;
               pend_n  = 1'b0;
            end else if (start_i) begin
               pend_n = 1'b1;
            end
         end
         default: state_n = REQ;
      endcase
   end

   // State register; reset parks in REQ so step 0 starts on release
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= REQ;
         step  <= 3'd0;
         tcnt  <= 8'd0;
         pend  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         step  <= step_n;
         tcnt  <= tcnt_n;
         pend  <= pend_n;
         err   <= err_n;
      end
   end

   assign in_seq = (state == REQ) || (state == WAIT);

   // Bus mux: sequencer owns the UART until DONE, then host passthrough
   always_comb begin
      m_adr_o = 5'd0;
      m_dat_o = 8'h00;
      m_we_o  = 1'b0;
      m_cyc_o = 1'b0;
      m_stb_o = 1'b0;
      s_dat_o = 8'h00;
      s_ack_o = 1'b0;
      if (!wb_rst_i) begin
         if (state == DONE) begin
            m_adr_o = s_adr_i;
            m_dat_o = s_dat_i;
            m_we_o  = s_we_i;
            m_cyc_o = s_cyc_i;
            m_stb_o = s_stb_i;
            s_dat_o = m_dat_i;
            s_ack_o = m_ack_i;
         end else if (in_seq) begin
            m_adr_o = tbl_adr;
            m_dat_o = tbl_dat;
            m_we_o  = 1'b1;
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
         end
      end
   end

   assign m_sel_o = m_cyc_o ? (4'b0001 << m_adr_o[1:0]) : 4'b0000;
   assign done_o  = !wb_rst_i && (state == DONE);
   assign busy_o  = !done_o;
   assign err_o   = !wb_rst_i && err;

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Directed bench for uart_cfg_sequencer: scoreboard queues of expected
// UART writes and host reads, popped by a negedge monitor.
module tb_uart_cfg_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       done;
   logic       busy;
   logic       err;
   logic [4:0] s_adr = 5'd0;
   logic [7:0] s_dat = 8'h00;
   logic [7:0] s_rdat;
   logic       s_we = 1'b0;
   logic       s_cyc = 1'b0;
   logic       s_stb = 1'b0;
   logic       s_ack;
   logic [4:0] m_adr;
   logic [7:0] m_dat;
   logic [7:0] m_rdat = 8'h00;
   logic [3:0] m_sel;
   logic       m_we;
   logic       m_cyc;
   logic       m_stb;
   logic       m_ack = 1'b0;

   typedef struct packed {
      logic [4:0] adr;
      logic [7:0] dat;
      logic [3:0] sel;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] rd_q[$];

   int total = 0;
   int bad = 0;
   int slat = 1;
   int acnt = 0;
   int nwr = 0;
   int cyc_n = 0;
   int last_ack = 0;
   int run = 0;
   int gap_armed = 0;
   int chk_done = 0;
   logic       prev_stb = 1'b0;
   logic [4:0] prev_adr = 5'd0;
   logic [7:0] prev_dat = 8'h00;

   uart_cfg_sequencer dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .start_i(start),
      .done_o(done),
      .busy_o(busy),
      .err_o(err),
      .s_adr_i(s_adr),
      .s_dat_i(s_dat),
      .s_dat_o(s_rdat),
      .s_we_i(s_we),
      .s_cyc_i(s_cyc),
      .s_stb_i(s_stb),
      .s_ack_o(s_ack),
      .m_adr_o(m_adr),
      .m_dat_o(m_dat),
      .m_dat_i(m_rdat),
      .m_sel_o(m_sel),
      .m_we_o(m_we),
      .m_cyc_o(m_cyc),
      .m_stb_o(m_stb),
      .m_ack_i(m_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // UART slave model: acks after slat strobe cycles, never if slat==0
   always @(posedge clk) begin
      if (m_cyc && m_stb && !m_ack && slat != 0) begin
         if (acnt == slat - 1) begin
            m_ack  <= 1'b1;
            acnt   <= 0;
            m_rdat <= {3'b101, m_adr};
         end else begin
            acnt <= acnt + 1;
         end
      end else begin
         m_ack <= 1'b0;
         acnt  <= 0;
      end
   end

   // Monitor: pops scoreboards on acks, checks gap/hold/done timing
   always @(negedge clk) begin
      wr_t e;
      logic [7:0] r;
      cyc_n++;
      if (rst) begin
         prev_stb = 1'b0;
      end else begin
         chk("busy_cmp", busy, !done);
         if (m_stb && !done) begin
            if (!prev_stb) begin
               run = 1;
               if (gap_armed != 0) chk("gap", cyc_n - last_ack, 2);
               gap_armed = 0;
            end else begin
               run++;
               chk("hold_adr", m_adr, prev_adr);
               chk("hold_dat", m_dat, prev_dat);
            end
         end
         if (chk_done != 0) begin
            chk("done_lat", {done, busy}, 2'b10);
            chk_done = 0;
         end
         if (m_cyc && m_stb && m_we && m_ack && !done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_write adr=%0h dat=%0h", m_adr, m_dat);
            end else begin
               e = exp_q.pop_front();
               chk("wr_adr", m_adr, e.adr);
               chk("wr_dat", m_dat, e.dat);
               chk("wr_sel", m_sel, e.sel);
               chk("stb_len", run, slat + 1);
               nwr++;
               last_ack = cyc_n;
               if (exp_q.size() == 0) chk_done = 1;
               else gap_armed = 1;
            end
         end
         if (s_ack) begin
            if (rd_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_host_ack dat=%0h", s_rdat);
            end else begin
               r = rd_q.pop_front();
               chk("rd_dat", s_rdat, r);
               chk("rd_after_done", done, 1);
            end
         end
         prev_stb = m_stb && !done;
         prev_adr = m_adr;
         prev_dat = m_dat;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq();
      exp_q.push_back({5'd3, 8'h83, 4'b1000});
      exp_q.push_back({5'd0, 8'h1B, 4'b0001});
      exp_q.push_back({5'd1, 8'h00, 4'b0010});
      exp_q.push_back({5'd3, 8'h03, 4'b1000});
      exp_q.push_back({5'd2, 8'hC7, 4'b0100});
      exp_q.push_back({5'd1, 8'h01, 4'b0010});
   endtask

   // Called at posedge+1; asserts reset at once and checks reset outputs
   task automatic do_reset(input int lat);
      rst = 1'b1;
      slat = lat;
      exp_q.delete();
      rd_q.delete();
      gap_armed = 0;
      chk_done = 0;
      nwr = 0;
      @(negedge clk);
      chk("rst_bus", {m_cyc, m_stb, m_we}, 3'b000);
      chk("rst_adr_dat", {m_adr, m_dat, m_sel}, 17'd0);
      chk("rst_flags", {done, err, s_ack, busy}, 4'b0001);
      chk("rst_rdat", s_rdat, 8'h00);
      repeat (2) tick();
      if (lat != 0) push_seq();
      rst = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (!done && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("done_reached", done, 1);
   endtask

   task automatic wait_nwr(input int k, input int maxc);
      int n = 0;
      while (nwr < k && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("nwr_reached", nwr >= k, 1);
   endtask

   initial begin
      int n;
      int busy_cyc;
      // 1: reset release, 1-cycle-ack slave, start ignored while busy
      tick();
      do_reset(1);
      @(negedge clk);
      chk("first_req", {m_cyc, m_adr, m_dat}, {1'b1, 5'd3, 8'h83});
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(200);
      chk("seq1_err", err, 0);
      chk("seq1_left", exp_q.size(), 0);

      // 2: slow slave plus host read stalled during step 2
      tick();
      do_reset(2);
      wait_nwr(2, 200);
      tick();
      s_adr = 5'd5;
      s_we = 1'b0;
      s_cyc = 1'b1;
      s_stb = 1'b1;
      rd_q.push_back(8'hA5);
      n = 0;
      @(negedge clk);
      while (!s_ack && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("rd_ack_seen", s_ack, 1);
      tick();
      s_cyc = 1'b0;
      s_stb = 1'b0;
      chk("seq2_err", err, 0);
      chk("rd_left", rd_q.size(), 0);

      // 3: slave never acks, timeout abandons the sequence
      tick();
      do_reset(0);
      wait_done(400);
      chk("to_run", run, 256);
      chk("to_flags", {err, done, m_cyc}, 3'b110);
      busy_cyc = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_cyc) busy_cyc++;
      end
      chk("to_no_more", busy_cyc, 0);

      // 4: start while host holds cyc is deferred until cyc falls
      slat = 1;
      tick();
      s_cyc = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      chk("pend_hold", {done, err}, 2'b11);
      tick();
      push_seq();
      s_cyc = 1'b0;
      @(negedge clk);
      chk("pend_wait", done, 1);
      @(negedge clk);
      chk("restart", {m_cyc, m_adr, m_dat}, {1'b1, 5'd3, 8'h83});
      chk("restart_flags", {done, err}, 2'b00);
      wait_done(200);
      chk("seq4_err", err, 0);

      // 5: reset during step 3 WAIT reissues all six writes
      tick();
      do_reset(6);
      wait_nwr(3, 300);
      n = 0;
      while (!m_stb && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("step3_req", {m_stb, m_adr, m_dat}, {1'b1, 5'd3, 8'h03});
      repeat (2) tick();
      do_reset(1);
      wait_done(200);
      chk("seq5_left", exp_q.size(), 0);
      chk("seq5_err", err, 0);

      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_cfg_sequencer.md
UART_CFG_SEQUENCER -- requirements
Module: uart_cfg_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of wb_clk_i.
REQ-002 Parameter DIVISOR SHALL default to 16'd27 and SHALL set the 16550 baud divisor (50 MHz clock, 115200 baud).
REQ-003 Parameter LCR_VAL SHALL default to 8'h03 and SHALL set the line control value (8N1).
REQ-004 Parameter FCR_VAL SHALL default to 8'hC7 and SHALL set the FIFO control value (enable and clear, trigger level 14).
REQ-005 Parameter IER_VAL SHALL default to 8'h01 and SHALL set the interrupt enable value (RX data available).
REQ-006 Parameter TIMEOUT SHALL default to 8'd255 and SHALL be the maximum number of cycles to wait for an ack.
REQ-007 The block SHALL have the following ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle request to rerun configuration
- done_o  out  1  configuration complete; host passthrough enabled
- busy_o  out  1  sequence in progress
- err_o  out  1  sticky ack-timeout flag
- s_adr_i  in  5  host address
- s_dat_i  in  8  host write data
- s_dat_o  out  8  host read data
- s_we_i  in  1  host write enable
- s_cyc_i  in  1  host cycle
- s_stb_i  in  1  host strobe
- s_ack_o  out  1  host ack
- m_adr_o  out  5  UART address
- m_dat_o  out  8  UART write data
- m_dat_i  in  8  UART read data
- m_sel_o  out  4  byte select
- m_we_o  out  1  UART write enable
- m_cyc_o  out  1  UART cycle
- m_stb_o  out  1  UART strobe
- m_ack_i  in  1  UART ack

Function
REQ-008 After reset the block SHALL start the configuration sequence automatically and SHALL issue these six Wishbone writes in order (address, data):
- (3, LCR_VAL|8'h80)
- (0, DIVISOR[7:0])
- (1, DIVISOR[15:8])
- (3, LCR_VAL&8'h7F)
- (2, FCR_VAL)
- (1, IER_VAL)
REQ-009 The state machine SHALL have the states IDLE_GAP, REQ, WAIT and DONE, with a 3-bit step counter running 0..5.
REQ-010 In REQ, m_cyc_o, m_stb_o and m_we_o SHALL be registered high and address/data SHALL be driven from the step table; the state SHALL then move to WAIT.
REQ-011 In WAIT, the strobe SHALL be held with address and data stable until m_ack_i=1 is sampled.
REQ-012 When the ack is sampled at edge N, cyc, stb and we SHALL be low from cycle N+1, and the next REQ SHALL assert from cycle N+2 (exactly one idle cycle between writes).
REQ-013 After the ack of step 5, done_o SHALL be 1 and busy_o SHALL be 0 from cycle N+1.
REQ-014 m_sel_o SHALL equal 4'b0001 << m_adr_o[1:0] whenever m_cyc_o=1.
REQ-015 In DONE, the m_* outputs SHALL follow the s_* inputs combinationally, with s_dat_o=m_dat_i and s_ack_o=m_ack_i.
REQ-016 While not in DONE, s_ack_o SHALL be 0 and host requests SHALL stall (not be dropped); they SHALL complete once passthrough is enabled.
REQ-017 The WAIT cycle counter SHALL reset on entry to WAIT; if it reaches TIMEOUT without an ack, the block SHALL:
- drop cyc and stb;
- set err_o=1;
- abandon the remaining steps;
- enter DONE.
REQ-018 A start_i pulse in DONE with s_cyc_i=0 SHALL clear done_o and err_o and restart at step 0 on the next cycle.
REQ-019 A start_i pulse in DONE with s_cyc_i=1 SHALL be latched as pending and acted on in the first cycle after s_cyc_i falls.
REQ-020 start_i SHALL be ignored while busy_o=1.
REQ-021 busy_o SHALL be the exact complement of done_o at all times after reset.

Reset
REQ-022 While wb_rst_i=1, the outputs SHALL be:
- m_cyc_o=0, m_stb_o=0, m_we_o=0;
- m_adr_o=0, m_dat_o=0, m_sel_o=0;
- done_o=0, err_o=0, s_ack_o=0, s_dat_o=0, busy_o=1;
- the step counter, timeout counter and pending-start flag cleared.
REQ-023 Reset asserted mid-write SHALL drop m_cyc_o at the next edge, and the sequence SHALL restart from step 0 in the first cycle after reset deasserts (REQ with (3, 8'h83)).

Verification
REQ-024 The bench SHALL cover these directed scenarios with default parameters:
- Reset release with a 1-cycle-ack slave -> writes (3,83), (0,1B), (1,00), (3,03), (2,C7), (1,01), one idle cycle between each, done_o=1 the cycle after the 6th ack, err_o=0.
- Slave acks 3 cycles after stb -> stb held 3 cycles; address and data unchanged until ack.
- Host read of adr 5 issued during step 2 -> s_ack_o=0 until done_o=1, then the read passes through and returns m_dat_i.
- Slave never acks -> after 255 cycles in WAIT for step 0: cyc low, err_o=1, done_o=1, no further steps issued.
- start_i while s_cyc_i=1 -> no restart; sequence restarts at (3,83) one cycle after s_cyc_i falls; err_o cleared.
- wb_rst_i pulsed during step 3 WAIT -> m_cyc_o=0 next edge; full six-write sequence reissued from step 0.
